slc_mem_responder: RTL and testbench

Memory-side responder for the SLC-3 datapath. It accepts a read or write request formed from MAR/MDR and the control FSM's MEM_REQ/MEM_WE, and runs a wait-stated external SRAM cycle. Read data returns on MDR_In with a one-cycle MEM_RDY pulse. Address IO_ADDR is memory-mapped I/O: reads return the switches and writes load the hex-display register.

---
 rtl/slc_mem_pkg.sv | 14 +
 rtl/mem_wait_counter.sv | 28 ++
 rtl/slc_mem_responder.sv | 104 ++++++++++
 tb/tb_slc_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/slc_mem_pkg.sv
// rtl/slc_mem_pkg.sv - shared types and constants for the SLC-3 memory responder
package slc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;
    localparam int          CNT_W           = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable wait-state down-counter with zero flag
import slc_mem_pkg::*;

module mem_wait_counter (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so a late decrement can never wrap into a long wait
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/slc_mem_responder.sv
// rtl/slc_mem_responder.sv - wait-stated SRAM / memory-mapped I/O responder for the SLC-3
import slc_mem_pkg::*;

module slc_mem_responder #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] SW,
    output logic [15:0] MDR_In,
    output logic        MEM_RDY,
    output logic        BUSY,
    output logic [15:0] HEX_OUT,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    mem_state_t state;
    logic       req_we;
    logic       cnt_zero;
    logic       sram_last;

    mem_wait_counter u_wait_counter (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (state == SETUP),
        .load_value (WAIT_LOAD),
        .dec        (state == WAIT),
        .zero       (cnt_zero)
    );

    // Final strobed cycle of an SRAM access: the read data is sampled on this edge
    assign sram_last = ((state == SETUP) && (WAIT_STATES == 0)) ||
                       ((state == WAIT) && cnt_zero);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            req_we      <= 1'b0;
            MDR_In      <= '0;
            MEM_RDY     <= 1'b0;
            BUSY        <= 1'b0;
            HEX_OUT     <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
        end else begin
            MEM_RDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (MEM_REQ) begin
                        req_we <= MEM_WE;
                        BUSY   <= 1'b1;
                        if (MAR == IO_ADDR) begin
                            state   <= DONE;
                            MEM_RDY <= 1'b1;
                            if (MEM_WE) HEX_OUT <= MDR;
                            else        MDR_In  <= SW;
                        end else begin
                            state     <= SETUP;
                            SRAM_ADDR <= MAR;
                            SRAM_CE_N <= 1'b0;
                            SRAM_OE_N <= MEM_WE;
                            SRAM_WE_N <= ~MEM_WE;
                            if (MEM_WE) SRAM_DQ_OUT <= MDR;
                        end
                    end
                end
                SETUP, WAIT: begin
                    if (sram_last) begin
                        state     <= DONE;
                        MEM_RDY   <= 1'b1;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        if (!req_we) MDR_In <= SRAM_DQ_IN;
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slc_mem_responder.sv
// tb/tb_slc_mem_responder.sv - self-checking bench for slc_mem_responder
module tb_slc_mem_responder;

    localparam int WS = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MEM_REQ = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] MAR = '0;
    logic [15:0] MDR = '0;
    logic [15:0] SW = '0;
    logic [15:0] MDR_In, HEX_OUT, SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_IN;
    logic        MEM_RDY, BUSY, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

    logic        req0 = 1'b0;
    logic        we0 = 1'b0;
    logic [15:0] mdr_in0, hex0, addr0, dq_out0, dq_in0;
    logic        rdy0, busy0, ce0_n, oe0_n, we0_n;

    int vectors = 0;
    int errors  = 0;
    int rdy_seen = 0;

    always #5 Clk = ~Clk;

    slc_mem_responder #(.WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) u_dut (
        .Clk(Clk), .Reset(Reset), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MAR(MAR), .MDR(MDR), .SW(SW), .MDR_In(MDR_In), .MEM_RDY(MEM_RDY),
        .BUSY(BUSY), .HEX_OUT(HEX_OUT), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_IN(SRAM_DQ_IN),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
    );

    slc_mem_responder #(.WAIT_STATES(0), .IO_ADDR(16'hFFFF)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .MEM_REQ(req0), .MEM_WE(we0),
        .MAR(MAR), .MDR(MDR), .SW(SW), .MDR_In(mdr_in0), .MEM_RDY(rdy0),
        .BUSY(busy0), .HEX_OUT(hex0), .SRAM_ADDR(addr0),
        .SRAM_DQ_OUT(dq_out0), .SRAM_DQ_IN(dq_in0),
        .SRAM_CE_N(ce0_n), .SRAM_OE_N(oe0_n), .SRAM_WE_N(we0_n)
    );

    assign dq_in0 = addr0 ^ 16'h5A5A;

    function automatic logic [15:0] preload(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {8'hC3, a};
    endfunction

    // External SRAM: untouched locations read back their preload pattern
    logic [15:0] sram [0:255];
    logic        sram_wr [0:255] = '{default: 1'b0};

    assign SRAM_DQ_IN = SRAM_OE_N ? 16'h0000 :
                        (sram_wr[SRAM_ADDR[7:0]] ? sram[SRAM_ADDR[7:0]] : preload(SRAM_ADDR[7:0]));

    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            sram[SRAM_ADDR[7:0]]    <= SRAM_DQ_OUT;
            sram_wr[SRAM_ADDR[7:0]] <= 1'b1;
        end
    end

    // Transaction-level reference: m_t counts edges since acceptance
    logic [15:0] ref_mem [0:255];
    logic        ref_wr [0:255] = '{default: 1'b0};
    logic        m_act = 1'b0, m_io = 1'b0, m_we = 1'b0;
    int          m_t = 0, m_len = 0;
    logic [15:0] m_addr = '0;
    logic [15:0] e_mdr = '0, e_hex = '0, e_addr = '0, e_dq = '0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_act = 1'b0; m_t = 0;
            e_mdr = '0; e_hex = '0; e_addr = '0; e_dq = '0;
        end else if (m_act) begin
            m_t = m_t + 1;
            if (m_t == m_len) m_act = 1'b0;
            else if (!m_io && !m_we && m_t == WS + 1)
                e_mdr = ref_wr[m_addr[7:0]] ? ref_mem[m_addr[7:0]] : preload(m_addr[7:0]);
        end else if (MEM_REQ) begin
            m_act = 1'b1; m_t = 0; m_we = MEM_WE; m_addr = MAR;
            m_io  = (MAR == 16'hFFFF);
            m_len = m_io ? 1 : WS + 2;
            if (m_io) begin
                if (MEM_WE) e_hex = MDR;
                else        e_mdr = SW;
            end else begin
                e_addr = MAR;
                if (MEM_WE) begin
                    e_dq = MDR;
                    ref_mem[MAR[7:0]] = MDR;
                    ref_wr[MAR[7:0]]  = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin : compare
        logic low;
        low = m_act && !m_io && (m_t <= WS);
        chk("mem_rdy",   {31'b0, MEM_RDY},   {31'b0, m_act && (m_t == m_len - 1)});
        chk("busy",      {31'b0, BUSY},      {31'b0, m_act});
        chk("ce_n",      {31'b0, SRAM_CE_N}, {31'b0, !low});
        chk("oe_n",      {31'b0, SRAM_OE_N}, {31'b0, !(low && !m_we)});
        chk("we_n",      {31'b0, SRAM_WE_N}, {31'b0, !(low && m_we)});
        chk("mdr_in",    {16'b0, MDR_In},    {16'b0, e_mdr});
        chk("hex_out",   {16'b0, HEX_OUT},   {16'b0, e_hex});
        chk("sram_addr", {16'b0, SRAM_ADDR}, {16'b0, e_addr});
        chk("sram_dq",   {16'b0, SRAM_DQ_OUT}, {16'b0, e_dq});
        if (MEM_RDY) rdy_seen++;
    end

    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output int ce_lo, output int oe_lo, output int we_lo);
        @(negedge Clk);
        MEM_WE = we; MAR = addr; MDR = data; MEM_REQ = 1'b1;
        @(negedge Clk);
        MEM_REQ = 1'b0;
        lat = 0; ce_lo = 0; oe_lo = 0; we_lo = 0;
        while (!MEM_RDY && lat < 40) begin
            if (!SRAM_CE_N) ce_lo++;
            if (!SRAM_OE_N) oe_lo++;
            if (!SRAM_WE_N) we_lo++;
            @(negedge Clk);
            lat++;
        end
        if (!MEM_RDY) chk("rdy_timeout", 32'd0, 32'd1);
        @(negedge Clk);
    endtask

    initial begin : stim
        int lat, ce_lo, oe_lo, we_lo;
        repeat (3) @(negedge Clk);
        chk("rst_rdy",  {31'b0, MEM_RDY},   32'd0);
        chk("rst_busy", {31'b0, BUSY},      32'd0);
        chk("rst_ce",   {31'b0, SRAM_CE_N}, 32'd1);
        chk("rst_mdr",  {16'b0, MDR_In},    32'd0);
        chk("rst_hex",  {16'b0, HEX_OUT},   32'd0);
        Reset = 1'b0;

        access(1'b0, 16'h0010, 16'h0000, lat, ce_lo, oe_lo, we_lo);
        chk("rd_lat",  lat, 32'd3);
        chk("rd_data", {16'b0, MDR_In}, 32'h0000BEEF);
        chk("rd_oe",   oe_lo, 32'd3);
        chk("rd_we",   we_lo, 32'd0);

        access(1'b1, 16'h0020, 16'h1234, lat, ce_lo, oe_lo, we_lo);
        chk("wr_we",   we_lo, 32'd3);
        chk("wr_oe",   oe_lo, 32'd0);
        chk("wr_dq",   {16'b0, SRAM_DQ_OUT}, 32'h00001234);
        chk("wr_mdr",  {16'b0, MDR_In}, 32'h0000BEEF);
        access(1'b0, 16'h0020, 16'h0000, lat, ce_lo, oe_lo, we_lo);
        chk("rb_data", {16'b0, MDR_In}, 32'h00001234);

        access(1'b1, 16'hFFFF, 16'h00A5, lat, ce_lo, oe_lo, we_lo);
        chk("io_wr_hex", {16'b0, HEX_OUT}, 32'h000000A5);
        chk("io_wr_lat", lat, 32'd0);
        chk("io_wr_ce",  ce_lo, 32'd0);
        SW = 16'h0F0F;
        access(1'b0, 16'hFFFF, 16'h0000, lat, ce_lo, oe_lo, we_lo);
        chk("io_rd_mdr", {16'b0, MDR_In}, 32'h00000F0F);
        chk("io_rd_lat", lat, 32'd0);
        chk("io_rd_hex", {16'b0, HEX_OUT}, 32'h000000A5);

        // Held request: back-to-back reads of a fresh location and the I/O port
        @(negedge Clk);
        MEM_WE = 1'b0; MAR = 16'h0030; MEM_REQ = 1'b1;
        repeat (10) @(negedge Clk);
        MAR = 16'hFFFF;
        repeat (4) @(negedge Clk);
        MEM_REQ = 1'b0;
        repeat (6) @(negedge Clk);

        // Request pulsed during WAIT is dropped
        rdy_seen = 0;
        MEM_WE = 1'b0; MAR = 16'h0010; MEM_REQ = 1'b1;
        @(negedge Clk);
        MEM_REQ = 1'b0;
        @(negedge Clk);
        MAR = 16'h0020; MEM_REQ = 1'b1;
        @(negedge Clk);
        MEM_REQ = 1'b0;
        repeat (8) @(negedge Clk);
        chk("pulse_rdy_count", rdy_seen, 32'd1);
        chk("pulse_mdr", {16'b0, MDR_In}, 32'h0000BEEF);

        // Reset during WAIT aborts without MEM_RDY
        rdy_seen = 0;
        MAR = 16'h0010; MEM_REQ = 1'b1;
        @(negedge Clk);
        MEM_REQ = 1'b0;
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("abort_ce", {31'b0, SRAM_CE_N}, 32'd1);
        chk("abort_oe", {31'b0, SRAM_OE_N}, 32'd1);
        chk("abort_mdr", {16'b0, MDR_In}, 32'd0);
        chk("abort_busy", {31'b0, BUSY}, 32'd0);
        @(negedge Clk);
        #2 Reset = 1'b0;
        repeat (6) @(negedge Clk);
        chk("abort_rdy_count", rdy_seen, 32'd0);
        chk("abort_idle", {31'b0, BUSY}, 32'd0);

        // Zero wait states on the second instance
        MAR = 16'h0033; req0 = 1'b1;
        @(negedge Clk);
        req0 = 1'b0;
        lat = 0;
        while (!rdy0 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        chk("ws0_lat",  lat, 32'd1);
        chk("ws0_data", {16'b0, mdr_in0}, 32'h00005A69);
        @(negedge Clk);
        chk("ws0_idle", {31'b0, busy0}, 32'd0);

        repeat (2) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
